// File: rtl/test_pattern_sequencer_pkg.sv
// Shared definitions for the video test-pattern path: sequencer states,
// the blank pattern index and the generator's pattern count.
package test_pattern_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_ARMED = 2'd1,
        ST_BLANK = 2'd2
    } seq_state_t;

    localparam logic [3:0] PATTERN_OFF      = 4'd0;
    localparam int         GEN_NUM_PATTERNS = 7;

    // One frame counter serves both the auto dwell and the blank dwell.
    function automatic int frame_cnt_width(input int fpp, input int blank);
        int m;
        m = (fpp > blank) ? fpp : blank;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/test_pattern_sequencer_frame_start_detect.sv
// Start-of-frame detector: one-cycle pulse on entry to column/row (0,0).
// A counter parked at (0,0) yields a single pulse.
module frame_start_detect #(
    parameter int COL_W = 10,
    parameter int ROW_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [COL_W-1:0] col,
    input  logic [ROW_W-1:0] row,
    output logic             sof
);

    logic at_origin;
    logic at_origin_q;

    assign at_origin = (col == '0) && (row == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            at_origin_q <= 1'b0;
        end else begin
            at_origin_q <= at_origin;
        end
    end

    assign sof = at_origin & ~at_origin_q;

endmodule

// File: rtl/test_pattern_sequencer.sv
// Frame-synchronous pattern select controller: manual/auto stepping with
// changes applied at start of frame and optional blank frames in between.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RUN   | showing current pattern; auto dwell counter runs on SOF
// ST_ARMED | target differs from current; waiting for the next SOF
// ST_BLANK | showing pattern 0 for BLANK_FRAMES frames before the switch
module test_pattern_sequencer
    import test_pattern_sequencer_pkg::*;
#(
    parameter int NUM_PATTERNS       = GEN_NUM_PATTERNS,
    parameter int RESET_PATTERN      = 5,
    parameter int FRAMES_PER_PATTERN = 120,
    parameter int BLANK_FRAMES       = 1
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Next,
    input  logic       i_Prev,
    input  logic       i_Auto_En,
    input  logic [9:0] i_Col_Count,
    input  logic [9:0] i_Row_Count,
    output logic [3:0] o_Pattern,
    output logic       o_Busy,
    output logic       o_Changed
);

    localparam int CNT_W = frame_cnt_width(FRAMES_PER_PATTERN, BLANK_FRAMES);
    localparam logic [CNT_W-1:0] AUTO_LAST  = CNT_W'(FRAMES_PER_PATTERN - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST =
        (BLANK_FRAMES > 0) ? CNT_W'(BLANK_FRAMES - 1) : '0;
    localparam logic [3:0] LAST_IDX  = 4'(NUM_PATTERNS - 1);
    localparam logic [3:0] RESET_IDX = 4'(RESET_PATTERN);

    seq_state_t       state;
    logic [3:0]       target;
    logic [3:0]       current;
    logic [CNT_W-1:0] frame_cnt;
    logic             sof;
    logic             req_fwd;
    logic             req_bwd;

    function automatic logic [3:0] step_fwd(input logic [3:0] p);
        return (p == LAST_IDX) ? 4'd0 : p + 4'd1;
    endfunction

    function automatic logic [3:0] step_bwd(input logic [3:0] p);
        return (p == 4'd0) ? LAST_IDX : p - 4'd1;
    endfunction

    // Simultaneous Next and Prev cancel out.
    assign req_fwd = i_Next & ~i_Prev;
    assign req_bwd = i_Prev & ~i_Next;

    frame_start_detect #(
        .COL_W(10),
        .ROW_W(10)
    ) u_sof (
        .clk(i_Clk),
        .rst(i_Rst),
        .col(i_Col_Count),
        .row(i_Row_Count),
        .sof(sof)
    );

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state     <= ST_RUN;
            target    <= RESET_IDX;
            current   <= RESET_IDX;
            frame_cnt <= '0;
            o_Pattern <= RESET_IDX;
            o_Busy    <= 1'b0;
            o_Changed <= 1'b0;
        end else begin
            o_Changed <= 1'b0;

            case (state)
                ST_RUN: begin
                    if (target != current) begin
                        state  <= ST_ARMED;
                        o_Busy <= 1'b1;
                    end else if (i_Auto_En && sof) begin
                        if (frame_cnt == AUTO_LAST) begin
                            target    <= step_fwd(target);
                            frame_cnt <= '0;
                            state     <= ST_ARMED;
                            o_Busy    <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt + CNT_W'(1);
                        end
                    end
                end

                ST_ARMED: begin
                    if (sof) begin
                        if (target == current) begin
                            state  <= ST_RUN;
                            o_Busy <= 1'b0;
                        end else if (BLANK_FRAMES == 0) begin
                            current   <= target;
                            o_Pattern <= target;
                            o_Changed <= 1'b1;
                            state     <= ST_RUN;
                            o_Busy    <= 1'b0;
                        end else begin
                            o_Pattern <= PATTERN_OFF;
                            frame_cnt <= '0;
                            state     <= ST_BLANK;
                        end
                    end
                end

                ST_BLANK: begin
                    if (sof) begin
                        if (frame_cnt == BLANK_LAST) begin
                            current   <= target;
                            o_Pattern <= target;
                            o_Changed <= 1'b1;
                            frame_cnt <= '0;
                            state     <= ST_RUN;
                            o_Busy    <= 1'b0;
                        end else begin
                            frame_cnt <= frame_cnt + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    state  <= ST_RUN;
                    o_Busy <= 1'b0;
                end
            endcase

            // Manual steps override the auto step; the blank dwell is not
            // restarted by a press.
            if (req_fwd) begin
                target <= step_fwd(target);
            end else if (req_bwd) begin
                target <= step_bwd(target);
            end
            if ((req_fwd || req_bwd) && (state != ST_BLANK)) begin
                frame_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_test_pattern_sequencer.sv
// Scoreboard bench for test_pattern_sequencer on a 16x8 frame: expected
// pattern changes are queued at stimulus time and popped on o_Changed.
module tb_test_pattern_sequencer;

    localparam int NP  = 7;
    localparam int FPP = 3;
    localparam int BF  = 1;
    localparam int RP  = 5;
    localparam int RP0 = 3;
    localparam int NF  = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] col = 10'd0;
    logic [9:0] row = 10'd0;
    logic       nxt = 1'b0, prv = 1'b0, auto_en = 1'b0;
    logic       nxt0 = 1'b0, prv0 = 1'b0, auto0 = 1'b0;
    logic [3:0] pat, pat0;
    logic       busy, busy0, chg, chg0;
    bit         stall = 1'b0;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int exp0_q[$];
    int m_target, m_current;

    always #5 clk = ~clk;

    test_pattern_sequencer #(
        .NUM_PATTERNS(NP), .RESET_PATTERN(RP),
        .FRAMES_PER_PATTERN(FPP), .BLANK_FRAMES(BF)
    ) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Next(nxt), .i_Prev(prv),
        .i_Auto_En(auto_en), .i_Col_Count(col), .i_Row_Count(row),
        .o_Pattern(pat), .o_Busy(busy), .o_Changed(chg)
    );

    test_pattern_sequencer #(
        .NUM_PATTERNS(NP), .RESET_PATTERN(RP0),
        .FRAMES_PER_PATTERN(FPP), .BLANK_FRAMES(0)
    ) dut0 (
        .i_Clk(clk), .i_Rst(rst), .i_Next(nxt0), .i_Prev(prv0),
        .i_Auto_En(auto0), .i_Col_Count(col), .i_Row_Count(row),
        .o_Pattern(pat0), .o_Busy(busy0), .o_Changed(chg0)
    );

    // 16x8 raster, optionally stalled in place.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!stall) begin
                if (col == 10'd15) begin
                    col = 10'd0;
                    row = (row == 10'd7) ? 10'd0 : row + 10'd1;
                end else begin
                    col = col + 10'd1;
                end
            end
        end
    end

    function automatic bit at(input int c, input int r);
        return (int'(col) == c) && (int'(row) == r);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic wait_at(input int c, input int r);
        int n;
        n = 0;
        @(negedge clk);
        while (!at(c, r)) begin
            n++;
            if (n > 400) begin
                checks++;
                errors++;
                $display("FAIL wait_at_timeout actual=none expected=(%0d,%0d)", c, r);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < n; i++) wait_at(0, 0);
    endtask

    task automatic press(input int c, input int r, input bit which, input bit nx, input bit pv);
        wait_at(c, r);
        if (which) begin
            nxt0 = nx;
            prv0 = pv;
        end else begin
            nxt = nx;
            prv = pv;
        end
        @(negedge clk);
        nxt = 1'b0; prv = 1'b0; nxt0 = 1'b0; prv0 = 1'b0;
    endtask

    // Monitor: independent SOF reference plus change scoreboard.
    initial begin : monitor
        bit origin_d, sof_d, here;
        int prev_pat;
        origin_d = 1'b0;
        sof_d    = 1'b0;
        prev_pat = RP;
        forever begin
            @(negedge clk);
            if (rst) begin
                origin_d = 1'b0;
                sof_d    = 1'b0;
            end else begin
                if (chg) begin
                    check("chg_after_sof", int'(sof_d), 1);
                    check("blank_before_chg", prev_pat, 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_chg actual=%0d expected=none", pat);
                    end else begin
                        check("chg_pattern", int'(pat), exp_q.pop_front());
                    end
                end
                if (chg0) begin
                    check("chg0_after_sof", int'(sof_d), 1);
                    if (exp0_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_chg0 actual=%0d expected=none", pat0);
                    end else begin
                        check("chg0_pattern", int'(pat0), exp0_q.pop_front());
                    end
                end
                here     = at(0, 0);
                sof_d    = here && !origin_d;
                origin_d = here;
            end
            prev_pat = int'(pat);
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int ef[NF];
        int idx, k, p;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_target  = RP;
        m_current = RP;
        check("rst_pattern", int'(pat), RP);
        check("rst_busy", int'(busy), 0);
        check("rst_chg", int'(chg), 0);
        check("rst_pattern0", int'(pat0), RP0);

        // Single Next mid-frame: busy one cycle later, one blank frame, then 6.
        press(7, 3, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(6);
        m_target = 6; m_current = 6;
        check("busy_req_cycle", int'(busy), 0);
        @(negedge clk);
        check("busy_rise", int'(busy), 1);
        check("hold_old", int'(pat), 5);
        wait_at(0, 0);
        check("hold_until_sof", int'(pat), 5);
        @(negedge clk);
        check("blank_frame", int'(pat), 0);
        wait_at(0, 0);
        check("blank_held", int'(pat), 0);
        @(negedge clk);
        check("new_pattern", int'(pat), 6);
        check("chg_pulse", int'(chg), 1);
        check("busy_fall", int'(busy), 0);

        // Wrap-around both ways.
        press(3, 2, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(0);
        wait_frames(3);
        check("wrap_fwd", int'(pat), 0);
        press(3, 2, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(6);
        wait_frames(3);
        check("wrap_bwd", int'(pat), 6);

        // Simultaneous requests, and a cancelled request.
        press(9, 4, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("both_busy", int'(busy), 0);
        wait_frames(2);
        check("both_pattern", int'(pat), 6);
        press(4, 2, 1'b0, 1'b1, 1'b0);
        press(4, 3, 1'b0, 1'b0, 1'b1);
        check("cancel_busy_armed", int'(busy), 1);
        wait_at(0, 0);
        @(negedge clk);
        check("cancel_no_blank", int'(pat), 6);
        check("cancel_busy", int'(busy), 0);

        // Reset in the middle of a blank frame.
        press(2, 2, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(0);
        wait_at(0, 0);
        @(negedge clk);
        check("blank_before_rst", int'(pat), 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        exp0_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_pattern", int'(pat), RP);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_chg", int'(chg), 0);
        @(negedge clk);
        check("rst_mid_hold", int'(pat), RP);
        m_target = RP; m_current = RP;

        // Randomized bursts of presses within one frame.
        for (int it = 0; it < 8; it++) begin
            int nn, np, nl, pl;
            bit isn;
            nn = $urandom_range(0, 3);
            np = $urandom_range(0, 3);
            nl = nn; pl = np;
            for (int j = 0; j < nn + np; j++) begin
                isn = (pl == 0) || ((nl > 0) && ($urandom_range(0, 1) == 1));
                if (isn) nl--; else pl--;
                press($urandom_range(0, 15), j + 1, 1'b0, isn, !isn);
            end
            m_target = (((m_target + nn - np) % NP) + NP) % NP;
            if (m_target != m_current) begin
                exp_q.push_back(m_target);
                m_current = m_target;
            end
            wait_frames(3);
            check("rand_pattern", int'(pat), m_current);
            check("rand_busy", int'(busy), 0);
        end

        // Auto-advance from reset: p0 shown FPP frames, every later pattern
        // is preceded by BF blank frames and then shown FPP+1 frames.
        wait_at(8, 4);
        rst = 1'b1;
        exp_q.delete();
        exp0_q.delete();
        auto_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idx = 0;
        k = 0;
        while (idx < NF) begin
            p = (RP + k) % NP;
            if (k == 0) begin
                for (int j = 0; j < FPP && idx < NF; j++) begin
                    ef[idx] = p;
                    idx++;
                end
            end else begin
                for (int j = 0; j < BF && idx < NF; j++) begin
                    ef[idx] = 0;
                    idx++;
                end
                for (int j = 0; j < FPP + 1 && idx < NF; j++) begin
                    if (j == 0) begin
                        exp_q.push_back(p);
                        m_current = p;
                    end
                    ef[idx] = p;
                    idx++;
                end
            end
            k++;
        end
        for (int f = 0; f < NF; f++) begin
            wait_at(0, 0);
            @(negedge clk);
            check($sformatf("auto_frame%0d", f), int'(pat), ef[f]);
        end
        auto_en = 1'b0;

        // Step to 2, then three Nexts in one frame land on 5 after one blank.
        press(5, 2, 1'b0, 1'b1, 1'b0);
        m_current = (m_current + 1) % NP;
        exp_q.push_back(m_current);
        wait_frames(3);
        check("pre_triple", int'(pat), 2);
        press(3, 2, 1'b0, 1'b1, 1'b0);
        press(3, 3, 1'b0, 1'b1, 1'b0);
        press(3, 4, 1'b0, 1'b1, 1'b0);
        exp_q.push_back((m_current + 3) % NP);
        wait_at(0, 0);
        @(negedge clk);
        check("triple_blank", int'(pat), 0);
        wait_at(0, 0);
        @(negedge clk);
        check("triple_target", int'(pat), 5);
        check("triple_chg", int'(chg), 1);

        // No blanking: Prev from 3 to 2 at the next SOF; raster parked at (0,0).
        press(5, 5, 1'b1, 1'b0, 1'b1);
        exp0_q.push_back(2);
        wait_at(0, 0);
        stall = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("nb_pattern", int'(pat0), 2);
                check("nb_chg", int'(chg0), 1);
                check("nb_busy", int'(busy0), 0);
            end
            if (i == 3) begin
                prv0 = 1'b1;
                exp0_q.push_back(1);
            end
            if (i == 4) prv0 = 1'b0;
        end
        check("stall_hold", int'(pat0), 2);
        check("stall_busy", int'(busy0), 1);
        stall = 1'b0;
        wait_at(0, 0);
        @(negedge clk);
        check("stall_release", int'(pat0), 1);
        check("stall_release_chg", int'(chg0), 1);

        repeat (4) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("exp0_q_drained", exp0_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
